ws2812b_strip_ctrl: RTL and testbench
=====================================

Name: ws2812b_strip_ctrl

Overview:
- Frame sequencer for one WS2812B chain.
- On a start pulse it walks a pixel RAM from address 0 to len-1. It reorders each 24-bit RGB word into the serial bit order of the ws2812b driver and hands it over with an enable/done handshake.
- After the last pixel it holds the line low for a latch gap, then reports frame completion.
- Sits between the CPU-written pixel RAM and the ws2812b bit-level driver.

Parameters:
- NUM_LEDS, 64, maximum pixels per frame; also the RAM depth.
- ADDR_W, 6, pixel RAM address width; requires 2^ADDR_W >= NUM_LEDS.
- LATCH_CYCLES, 2600, clk cycles of enforced idle after the last pixel. Default is >50 us at 48 MHz.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to send a frame
- len  in  ADDR_W+1  pixels in this frame, sampled with start
- busy  out  1  high from accepted start until frame_done
- frame_done  out  1  one-cycle pulse at end of frame
- mem_addr  out  ADDR_W  pixel RAM read address
- mem_rd  out  1  pixel RAM read strobe
- mem_rdata  in  24  {R[7:0],G[7:0],B[7:0]}; valid the cycle after mem_rd
- drv_data  out  24  word to the driver, transmitted LSB first
- drv_enable  out  1  load request to the driver
- drv_done  in  1  driver idle/complete flag

Behaviour:
- Reset values: busy=0, frame_done=0, mem_addr=0, mem_rd=0, drv_data=0, drv_enable=0. FSM returns to IDLE; latch and pixel counters clear.
- Reset mid-frame aborts immediately. drv_enable drops in the same cycle; the driver finishes its current word on its own.
- FSM states: IDLE, FETCH, CAPTURE, LOAD, WAIT_LOW, WAIT_HIGH, LATCH, DONE.
- IDLE:
  - start=1 with len=0 goes to DONE; the driver is never touched and there is no latch.
  - start=1 with len>0 latches count=min(len,NUM_LEDS), sets busy=1 and goes to FETCH.
  - start is ignored in every other state.
- FETCH: mem_rd=1 for one cycle with mem_addr=index; go to CAPTURE.
- CAPTURE: register mem_rdata into the pixel register; go to LOAD. mem_rd=0.
- Color reorder: drv_data is the bit-reverse of {G,R,B}. drv_data[0]=G[7], drv_data[7]=G[0], drv_data[8]=R[7], drv_data[23]=B[0]. This makes the wire order GRB, MSB first.
- LOAD:
  - drv_enable=1 with drv_data stable, held until a cycle where drv_enable && drv_done; that cycle is the transfer.
  - drv_enable=0 the following cycle; go to WAIT_LOW.
  - If drv_done is already high on LOAD entry, the transfer completes in that cycle. Latency from start to the first drv_enable is 3 cycles.
- WAIT_LOW: wait for drv_done=0 (the driver accepted the word); go to WAIT_HIGH. drv_done=0 in the cycle after the transfer is expected, but extra cycles are tolerated.
- WAIT_HIGH: wait for drv_done=1.
  - If index == count-1, go to LATCH.
  - Otherwise increment index and go to FETCH.
- LATCH: hold drv_enable=0 for exactly LATCH_CYCLES cycles, then go to DONE.
- DONE: frame_done=1 for one cycle, busy=0, go to IDLE. A start arriving on the DONE cycle is ignored.
- Widths: index is ADDR_W bits and never wraps, because count <= NUM_LEDS. The latch counter is $clog2(LATCH_CYCLES+1) bits.
- len > NUM_LEDS is clamped to NUM_LEDS.

Optional Feature:
- Macro: WS2812B_BRIGHTNESS_EN.
- Enabled:
  - Adds input brightness [7:0].
  - Each channel in CAPTURE becomes (c*(brightness+1))>>8, computed in 16 bits and truncated to 8.
  - brightness=255 passes data unchanged; brightness=0 yields 0 for any channel.
  - brightness is sampled with start and held for the whole frame.
- Disabled: the port does not exist and channels pass through unscaled. Timing is identical either way.

Test Plan:
- Pixel RAM[0]=24'hFF0000 (red), len=1, driver model with done→0 one cycle after load and done→1 after 100 cycles:
  - drv_data=24'h00FF00, because the bit-reverse of {G=00,R=FF,B=00} puts R at bits 15:8.
  - One transfer, then exactly 2600 LATCH cycles, then a frame_done pulse and busy low.
- RAM[0..2]=24'h123456, 24'hABCDEF, 24'h000001, len=3: three transfers in address order.
  - Third word is drv_data[23]=1, all other bits 0.
  - mem_rd asserted exactly 3 times.
- len=0: frame_done pulses 2 cycles after start; drv_enable and mem_rd never assert.
- len=100 with NUM_LEDS=64: exactly 64 transfers; last mem_addr=63.
- start re-pulsed during WAIT_HIGH: ignored, transfer count unchanged.
- reset during pixel 2 of 3: drv_enable=0 next cycle and all outputs at reset values. A new start then begins again from address 0.
- WS2812B_BRIGHTNESS_EN defined:
  - brightness=127 with 24'hFFFFFF gives channels 8'h7F.
  - brightness=0 gives drv_data=0 while transfers still occur.

Source files
------------

// File: rtl/ws2812b_strip_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812b_strip_ctrl
//  Description : Frame sequencer for a single WS2812B chain. Walks the pixel
//                RAM from address 0 to len-1 and reorders each RGB word into
//                the driver's LSB-first GRB bit order. Each word is handed to
//                the bit-level driver through an enable/done handshake. After
//                the last pixel a latch gap is enforced before frame_done.
//                Optional macro WS2812B_BRIGHTNESS_EN adds a global
//                brightness input that scales every channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812b_strip_ctrl #(
  parameter int NUM_LEDS     = 64,
  parameter int ADDR_W       = 6,
  parameter int LATCH_CYCLES = 2600
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
`ifdef WS2812B_BRIGHTNESS_EN
  input  logic [7:0]        brightness,
`endif
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [23:0]       mem_rdata,
  output logic [23:0]       drv_data,
  output logic              drv_enable,
  input  logic              drv_done
);

  localparam int                  c_latch_w    = $clog2(LATCH_CYCLES + 1);
  localparam logic [ADDR_W:0]     c_num_leds   = (ADDR_W + 1)'(NUM_LEDS);
  localparam logic [c_latch_w-1:0] c_latch_last = c_latch_w'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_CAPTURE   = 3'd2,
    S_LOAD      = 3'd3,
    S_WAIT_LOW  = 3'd4,
    S_WAIT_HIGH = 3'd5,
    S_LATCH     = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t               state_q;
  logic [ADDR_W-1:0]    index_q;
  logic [ADDR_W:0]      count_q;
  logic [c_latch_w-1:0] latch_q;
  logic                 busy_q;
  logic                 frame_done_q;
  logic                 mem_rd_q;
  logic                 drv_enable_q;
  logic [23:0]          drv_data_q;

  logic [ADDR_W:0]      count_d;
  logic [23:0]          drv_data_d;
  logic [7:0]           red_s;
  logic [7:0]           grn_s;
  logic [7:0]           blu_s;
  logic [23:0]          grb_s;
  logic                 last_pixel;

`ifdef WS2812B_BRIGHTNESS_EN
  logic [7:0]           bright_q;

  // c*(b+1)>>8: b=255 is an exact pass-through, b=0 blanks the channel
  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, b} + 16'd1);
    return prod[15:8];
  endfunction
`endif

  // Pixel count for the frame, clamped to the RAM depth
  always_comb begin
    count_d = (len > c_num_leds) ? c_num_leds : len;
  end

  // Channel scaling and GRB reorder; bit-reversal makes the LSB-first driver emit G7 first
  always_comb begin
`ifdef WS2812B_BRIGHTNESS_EN
    red_s = scale8(mem_rdata[23:16], bright_q);
    grn_s = scale8(mem_rdata[15:8],  bright_q);
    blu_s = scale8(mem_rdata[7:0],   bright_q);
`else
    red_s = mem_rdata[23:16];
    grn_s = mem_rdata[15:8];
    blu_s = mem_rdata[7:0];
`endif
    grb_s      = {grn_s, red_s, blu_s};
    drv_data_d = {<<{grb_s}};
  end

  assign last_pixel = (({1'b0, index_q} + 1'b1) == count_q);

  // Frame sequencer; all outputs are registered and set on the edge entering each phase
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      index_q      <= '0;
      count_q      <= '0;
      latch_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      mem_rd_q     <= 1'b0;
      drv_enable_q <= 1'b0;
      drv_data_q   <= '0;
`ifdef WS2812B_BRIGHTNESS_EN
      bright_q     <= '0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      mem_rd_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (len == '0) begin
              state_q <= S_DONE;
            end else begin
              count_q  <= count_d;
              index_q  <= '0;
              busy_q   <= 1'b1;
              mem_rd_q <= 1'b1;
`ifdef WS2812B_BRIGHTNESS_EN
              bright_q <= brightness;
`endif
              state_q  <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          drv_data_q   <= drv_data_d;
          drv_enable_q <= 1'b1;
          state_q      <= S_LOAD;
        end
        S_LOAD: begin
          if (drv_done) begin
            drv_enable_q <= 1'b0;
            state_q      <= S_WAIT_LOW;
          end
        end
        S_WAIT_LOW: begin
          if (!drv_done) begin
            state_q <= S_WAIT_HIGH;
          end
        end
        S_WAIT_HIGH: begin
          if (drv_done) begin
            if (last_pixel) begin
              latch_q <= '0;
              state_q <= S_LATCH;
            end else begin
              index_q  <= index_q + 1'b1;
              mem_rd_q <= 1'b1;
              state_q  <= S_FETCH;
            end
          end
        end
        S_LATCH: begin
          if (latch_q == c_latch_last) begin
            state_q <= S_DONE;
          end else begin
            latch_q <= latch_q + 1'b1;
          end
        end
        S_DONE: begin
          frame_done_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign mem_addr   = index_q;
  assign mem_rd     = mem_rd_q;
  assign drv_data   = drv_data_q;
  assign drv_enable = drv_enable_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812b_strip_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ws2812b_strip_ctrl
//  Description : Self-checking bench for ws2812b_strip_ctrl. Each frame is
//                planned up front as a cycle timeline (start/len/drv_done/
//                reset stimulus plus the expected outputs) derived from the
//                sequencing rules, then replayed and compared every cycle.
//                Honours WS2812B_BRIGHTNESS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812b_strip_ctrl;

  localparam int NUM_LEDS     = 64;
  localparam int ADDR_W       = 6;
  localparam int LATCH_CYCLES = 2600;
  localparam int MAXC         = 8192;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              frame_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [23:0]       mem_rdata;
  logic [23:0]       drv_data;
  logic              drv_enable;
  logic              drv_done;
`ifdef WS2812B_BRIGHTNESS_EN
  logic [7:0]        brightness;
`endif

  always #5 clk = ~clk;

  ws2812b_strip_ctrl #(
    .NUM_LEDS    (NUM_LEDS),
    .ADDR_W      (ADDR_W),
    .LATCH_CYCLES(LATCH_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
`ifdef WS2812B_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .busy       (busy),
    .frame_done (frame_done),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .drv_data   (drv_data),
    .drv_enable (drv_enable),
    .drv_done   (drv_done)
  );

  // Pixel RAM: data valid the cycle after a read strobe, noise otherwise
  logic [23:0] ram [NUM_LEDS];
  always @(posedge clk) mem_rdata <= mem_rd ? ram[mem_addr] : 24'($urandom);

  int vectors     = 0;
  int miscompares = 0;

  // Planned timeline, indexed by cycle relative to the start pulse
  bit         p_start [MAXC];
  logic [6:0] p_len   [MAXC];
  bit         p_done  [MAXC];
  bit         p_reset [MAXC];
  logic [7:0] p_bri   [MAXC];
  bit         x_busy  [MAXC];
  bit         x_rd    [MAXC];
  bit         x_en    [MAXC];
  bit         x_fd    [MAXC];
  int         x_aset  [MAXC];   // -1 hold, -2 clear, else new address
  int         x_dset  [MAXC];   // -1 hold, -2 clear, else new word
  int         plan_last;

  logic [ADDR_W-1:0] m_addr;
  logic [23:0]       m_data;

  // Word as the driver must receive it: bit k is the k-th bit on the wire (G7 first)
  function automatic logic [23:0] wire_order(input logic [23:0] rgb, input int bri);
    logic [7:0]  r, g, b;
    logic [23:0] grb, res;
    r = rgb[23:16]; g = rgb[15:8]; b = rgb[7:0];
    if (bri >= 0) begin
      r = 8'((int'(r) * (bri + 1)) / 256);
      g = 8'((int'(g) * (bri + 1)) / 256);
      b = 8'((int'(b) * (bri + 1)) / 256);
    end
    grb = {g, r, b};
    for (int k = 0; k < 24; k++) res[k] = grb[23 - k];
    return res;
  endfunction

  task automatic expect_val(input string nm, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, want);
    end
  endtask

  // Build the whole timeline of one frame from the sequencing rules
  task automatic plan_frame(input int len_in, input int bri_in, input int dmax, input int kmax,
                            input int lmin, input int lmax, input int rst_px, input bit noise);
    int n, a, d, k, l, e, t, h, fd, stop, bri;
    for (int r = 0; r < MAXC; r++) begin
      p_start[r] = 0; p_len[r] = 7'($urandom); p_done[r] = 1; p_reset[r] = 0;
      p_bri[r] = 8'($urandom);
      x_busy[r] = 0; x_rd[r] = 0; x_en[r] = 0; x_fd[r] = 0; x_aset[r] = -1; x_dset[r] = -1;
    end
    n = (len_in > NUM_LEDS) ? NUM_LEDS : len_in;
    p_start[0] = 1;
    p_len[0]   = 7'(len_in);
    bri        = -1;
`ifdef WS2812B_BRIGHTNESS_EN
    p_bri[0] = 8'(bri_in);
    bri      = bri_in;
`endif
    if (n == 0) begin
      if (noise) p_start[1] = 1;
      x_fd[2]   = 1;
      plan_last = 4;
      return;
    end
    a = 0; stop = -1;
    for (int i = 0; i < n && stop < 0; i++) begin
      d = $urandom_range(dmax, 0);
      for (int c = a + 1; c <= a + d; c++) p_done[c] = 0;
      x_rd[a + 1]   = 1;
      x_aset[a + 1] = i;
      e = a + 3;
      x_dset[e] = int'(wire_order(ram[i], bri));
      t = (a + d + 1 > e) ? a + d + 1 : e;
      for (int c = e; c <= t; c++) x_en[c] = 1;
      if (i == rst_px) stop = e;
      k = $urandom_range(kmax, 0);
      l = $urandom_range(lmax, lmin);
      for (int c = t + k + 1; c <= t + k + l; c++) p_done[c] = 0;
      h = t + k + l + 1;
      if (noise) p_start[$urandom_range(h, t + k + 2)] = 1;
      a = h;
    end
    if (stop >= 0) begin
      p_reset[stop] = 1;
      for (int r = stop + 1; r < MAXC; r++) begin
        p_done[r] = 1; p_start[r] = 0; x_en[r] = 0; x_rd[r] = 0; x_fd[r] = 0;
        x_aset[r] = -1; x_dset[r] = -1;
      end
      x_aset[stop + 1] = -2;
      x_dset[stop + 1] = -2;
      for (int r = 1; r <= stop; r++) x_busy[r] = 1;
      plan_last = stop + 3;
      return;
    end
    fd = a + LATCH_CYCLES + 2;
    x_fd[fd] = 1;
    for (int r = 1; r < fd; r++) x_busy[r] = 1;
    if (noise) begin
      p_start[fd - 1] = 1;
      p_start[$urandom_range(fd - 2, a + 1)] = 1;
    end
    plan_last = fd + 2;
  endtask

  // Replay the plan, compare every cycle and collect frame statistics
  task automatic run_frame(input string nm, output int n_xfer, output int n_rd, output int n_en,
                           output int last_addr, output int fd_r, output int rise_r);
    bit prev_done;
    n_xfer = 0; n_rd = 0; n_en = 0; last_addr = -1; fd_r = -1; rise_r = -1; prev_done = 1;
    for (int r = 0; r <= plan_last; r++) begin
      reset = p_reset[r]; start = p_start[r]; len = p_len[r]; drv_done = p_done[r];
`ifdef WS2812B_BRIGHTNESS_EN
      brightness = p_bri[r];
`endif
      if (x_aset[r] == -2) m_addr = '0;
      else if (x_aset[r] >= 0) m_addr = ADDR_W'(x_aset[r]);
      if (x_dset[r] == -2) m_data = '0;
      else if (x_dset[r] >= 0) m_data = 24'(x_dset[r]);
      @(negedge clk);
      vectors++;
      if ({busy, frame_done, mem_rd, drv_enable, mem_addr, drv_data} !==
          {x_busy[r], x_fd[r], x_rd[r], x_en[r], m_addr, m_data}) begin
        miscompares++;
        $display("FAIL %s cycle %0d busy/fd/rd/en/addr/data: got %b%b%b%b/%0d/%h expected %b%b%b%b/%0d/%h",
                 nm, r, busy, frame_done, mem_rd, drv_enable, mem_addr, drv_data,
                 x_busy[r], x_fd[r], x_rd[r], x_en[r], m_addr, m_data);
      end
      if (drv_enable && drv_done) n_xfer++;
      if (drv_enable) n_en++;
      if (mem_rd) begin n_rd++; last_addr = int'(mem_addr); end
      if (frame_done) fd_r = r;
      if (drv_done && !prev_done) rise_r = r;
      prev_done = drv_done;
      @(posedge clk); #1;
    end
  endtask

  int nx, nr, ne, la, fr, rr;

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; drv_done = 1'b1;
`ifdef WS2812B_BRIGHTNESS_EN
    brightness = 8'd0;
`endif
    for (int i = 0; i < NUM_LEDS; i++) ram[i] = 24'($urandom);
    m_addr = '0; m_data = '0;

    // Hand-derived reorder results pinning the model
    expect_val("pin_red",    int'(wire_order(24'hFF0000, -1)), 24'h00FF00);
    expect_val("pin_123456", int'(wire_order(24'h123456, -1)), 24'h6A482C);
    expect_val("pin_abcdef", int'(wire_order(24'hABCDEF, -1)), 24'hF7D5B3);
    expect_val("pin_000001", int'(wire_order(24'h000001, -1)), 24'h800000);
`ifdef WS2812B_BRIGHTNESS_EN
    expect_val("pin_bri127", int'(wire_order(24'hFFFFFF, 127)), 24'hFEFEFE);
    expect_val("pin_bri255", int'(wire_order(24'h123456, 255)), 24'h6A482C);
`endif

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    expect_val("reset_state", int'({busy, frame_done, mem_rd, drv_enable, mem_addr, drv_data}), 0);
    @(posedge clk); #1;

    // Single red pixel, slow driver
    ram[0] = 24'hFF0000;
    plan_frame(1, 255, 0, 0, 100, 100, -1, 0);
    run_frame("red", nx, nr, ne, la, fr, rr);
    expect_val("red_xfers", nx, 1);
    expect_val("red_data", int'(drv_data), 24'h00FF00);
    expect_val("red_latch_gap", fr - rr, 2602);
    expect_val("red_busy_after", int'(busy), 0);

    // Three pixels in address order
    ram[0] = 24'h123456; ram[1] = 24'hABCDEF; ram[2] = 24'h000001;
    plan_frame(3, 255, 2, 2, 1, 6, -1, 0);
    run_frame("three", nx, nr, ne, la, fr, rr);
    expect_val("three_xfers", nx, 3);
    expect_val("three_reads", nr, 3);
    expect_val("three_last_data", int'(drv_data), 24'h800000);

    // Empty frame
    plan_frame(0, 255, 0, 0, 1, 1, -1, 1);
    run_frame("len0", nx, nr, ne, la, fr, rr);
    expect_val("len0_done_at", fr, 2);
    expect_val("len0_enables", ne, 0);
    expect_val("len0_reads", nr, 0);

    // Oversized frame is clamped
    for (int i = 0; i < NUM_LEDS; i++) ram[i] = 24'($urandom);
    plan_frame(100, 255, 1, 1, 1, 3, -1, 0);
    run_frame("clamp", nx, nr, ne, la, fr, rr);
    expect_val("clamp_xfers", nx, 64);
    expect_val("clamp_last_addr", la, 63);

    // Start pulses while busy are ignored
    plan_frame(3, 255, 3, 2, 2, 8, -1, 1);
    run_frame("restart", nx, nr, ne, la, fr, rr);
    expect_val("restart_xfers", nx, 3);

    // Reset while pixel 2 of 3 is being loaded, then a fresh frame
    plan_frame(3, 255, 2, 1, 2, 5, 1, 0);
    run_frame("abort", nx, nr, ne, la, fr, rr);
    expect_val("abort_outputs", int'({busy, frame_done, mem_rd, drv_enable, mem_addr, drv_data}), 0);
    plan_frame(2, 255, 2, 1, 1, 4, -1, 0);
    run_frame("after_abort", nx, nr, ne, la, fr, rr);
    expect_val("after_abort_xfers", nx, 2);

`ifdef WS2812B_BRIGHTNESS_EN
    ram[0] = 24'hFFFFFF;
    plan_frame(1, 127, 1, 1, 1, 4, -1, 0);
    run_frame("bri127", nx, nr, ne, la, fr, rr);
    expect_val("bri127_data", int'(drv_data), 24'hFEFEFE);
    for (int i = 0; i < NUM_LEDS; i++) ram[i] = 24'($urandom) | 24'h010101;
    plan_frame(3, 0, 1, 1, 1, 4, -1, 1);
    run_frame("bri0", nx, nr, ne, la, fr, rr);
    expect_val("bri0_xfers", nx, 3);
    expect_val("bri0_data", int'(drv_data), 0);
`endif

    // Randomized frames
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NUM_LEDS; i++) ram[i] = 24'($urandom);
      plan_frame($urandom_range(70, 1), $urandom_range(255, 0), 4, 2, 1, 10, -1, 1'($urandom));
      run_frame("random", nx, nr, ne, la, fr, rr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
